// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap/mret sequencing, interrupt enables and 64-bit counters.
// Build option: define CSR_COUNTERS_EN to include the mcycle/minstret counter hardware.
module csr_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        instret_pulse,
    input  logic        trap_en,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret_en,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] IRQ_MASK   = 32'h0000_0888;

    function automatic logic [31:0] align4(input logic [31:0] value);
        return value & ~32'h3;
    endfunction

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_mask;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mip;
    logic [31:0] mstatus_view;

    always_comb begin
        mip     = '0;
        mip[11] = irq_ext;
        mip[7]  = irq_timer;
        mip[3]  = irq_soft;
    end

    // MPP is hardwired to machine mode.
    always_comb begin
        mstatus_view        = '0;
        mstatus_view[12:11] = 2'b11;
        mstatus_view[7]     = status_mpie;
        mstatus_view[3]     = status_mie;
    end

    // Trap beats mret beats software writes on shared registers; other writes still land.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_mask    <= '0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
        end else begin
            if (trap_en) begin
                mepc        <= align4(trap_pc);
                mcause      <= trap_cause;
                mtval       <= trap_val;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mret_en) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end
            if (csr_wen) begin
                case (csr_waddr)
                    ADDR_MSTATUS: begin
                        if (!trap_en && !mret_en) begin
                            status_mie  <= csr_wdata[3];
                            status_mpie <= csr_wdata[7];
                        end
                    end
                    ADDR_MIE:      mie_mask <= csr_wdata & IRQ_MASK;
                    ADDR_MTVEC:    mtvec    <= align4(csr_wdata);
                    ADDR_MSCRATCH: mscratch <= csr_wdata;
                    ADDR_MEPC:     if (!trap_en) mepc   <= align4(csr_wdata);
                    ADDR_MCAUSE:   if (!trap_en) mcause <= csr_wdata;
                    ADDR_MTVAL:    if (!trap_en) mtval  <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // A software write to either half replaces this cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_wen && csr_waddr == ADDR_MCYCLE)
                mcycle <= {mcycle[63:32], csr_wdata};
            else if (csr_wen && csr_waddr == ADDR_MCYCLEH)
                mcycle <= {csr_wdata, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;

            if (csr_wen && csr_waddr == ADDR_MINSTRET)
                minstret <= {minstret[63:32], csr_wdata};
            else if (csr_wen && csr_waddr == ADDR_MINSTRETH)
                minstret <= {csr_wdata, minstret[31:0]};
            else if (instret_pulse)
                minstret <= minstret + 64'd1;
        end
    end
`else
    logic unused_instret;
    assign unused_instret = instret_pulse;
`endif

    always_comb begin
        csr_rdata   = '0;
        csr_illegal = 1'b0;
        case (csr_raddr)
            ADDR_MSTATUS:  csr_rdata = mstatus_view;
            ADDR_MISA:     csr_rdata = MISA_VALUE;
            ADDR_MIE:      csr_rdata = mie_mask;
            ADDR_MTVEC:    csr_rdata = mtvec;
            ADDR_MSCRATCH: csr_rdata = mscratch;
            ADDR_MEPC:     csr_rdata = mepc;
            ADDR_MCAUSE:   csr_rdata = mcause;
            ADDR_MTVAL:    csr_rdata = mtval;
            ADDR_MIP:      csr_rdata = mip;
            ADDR_MHARTID:  csr_rdata = '0;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    csr_rdata = mcycle[31:0];
            ADDR_MCYCLEH:   csr_rdata = mcycle[63:32];
            ADDR_MINSTRET:  csr_rdata = minstret[31:0];
            ADDR_MINSTRETH: csr_rdata = minstret[63:32];
`else
            ADDR_MCYCLE, ADDR_MCYCLEH,
            ADDR_MINSTRET, ADDR_MINSTRETH: csr_rdata = '0;
`endif
            default: csr_illegal = 1'b1;
        endcase
    end

    assign mtvec_out   = mtvec;
    assign mepc_out    = mepc;
    assign irq_pending = status_mie && ((mip & mie_mask) != '0);

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus randomized traffic against a reference model.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        instret_pulse;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret_en;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;

    int checks = 0;
    int errors = 0;

    csr_regfile dut (
        .clk(clk), .rst(rst),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .instret_pulse(instret_pulse),
        .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
        .mret_en(mret_en),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                   12'hB82, 12'hF14, 12'h7C0, 12'h306};

    task automatic model_update();
        bit wr, old_mie, old_mpie;
        wr = csr_wen;
        old_mie = m_mie;
        old_mpie = m_mpie;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 0; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_tval = 0; m_cycle = 0; m_instret = 0;
        end else begin
            if (wr && csr_waddr == 12'hB00) m_cycle[31:0] = csr_wdata;
            else if (wr && csr_waddr == 12'hB80) m_cycle[63:32] = csr_wdata;
            else m_cycle = m_cycle + 1;
            if (wr && csr_waddr == 12'hB02) m_instret[31:0] = csr_wdata;
            else if (wr && csr_waddr == 12'hB82) m_instret[63:32] = csr_wdata;
            else if (instret_pulse) m_instret = m_instret + 1;

            if (trap_en) begin
                m_epc = trap_pc & 32'hFFFF_FFFC;
                m_cause = trap_cause;
                m_tval = trap_val;
                m_mpie = old_mie;
                m_mie = 0;
            end else if (mret_en) begin
                m_mie = old_mpie;
                m_mpie = 1;
            end
            if (wr) begin
                if (csr_waddr == 12'h300 && !trap_en && !mret_en) begin
                    m_mie = csr_wdata[3];
                    m_mpie = csr_wdata[7];
                end
                if (csr_waddr == 12'h304) m_ie = csr_wdata & 32'h888;
                if (csr_waddr == 12'h305) m_tvec = csr_wdata & 32'hFFFF_FFFC;
                if (csr_waddr == 12'h340) m_scratch = csr_wdata;
                if (!trap_en) begin
                    if (csr_waddr == 12'h341) m_epc = csr_wdata & 32'hFFFF_FFFC;
                    if (csr_waddr == 12'h342) m_cause = csr_wdata;
                    if (csr_waddr == 12'h343) m_tval = csr_wdata;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_mip();
        return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_soft ? 32'h8 : 32'h0);
    endfunction

    task automatic exp_read(input logic [11:0] a, output logic [31:0] d, output bit ill);
        ill = 0;
        case (a)
            12'h300: d = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: d = 32'h4000_0100;
            12'h304: d = m_ie;
            12'h305: d = m_tvec;
            12'h340: d = m_scratch;
            12'h341: d = m_epc;
            12'h342: d = m_cause;
            12'h343: d = m_tval;
            12'h344: d = m_mip();
            12'hF14: d = 0;
`ifdef CSR_COUNTERS_EN
            12'hB00: d = m_cycle[31:0];
            12'hB80: d = m_cycle[63:32];
            12'hB02: d = m_instret[31:0];
            12'hB82: d = m_instret[63:32];
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82: d = 0;
`endif
            default: begin d = 0; ill = 1; end
        endcase
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; csr_wen = 0; csr_waddr = 0; csr_wdata = 0; instret_pulse = 0;
        trap_en = 0; trap_pc = 0; trap_cause = 0; trap_val = 0; mret_en = 0;
        irq_ext = 0; irq_timer = 0; irq_soft = 0; csr_raddr = 12'h300;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_wen = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        csr_wen = 1; csr_waddr = 12'h305; csr_wdata = 32'h1234_5678;
        trap_en = 1; trap_pc = 32'hDEAD_BEEF; mret_en = 1; irq_ext = 1;
        tick();
        tick();
        idle_inputs();
        #1;
        checks++;
        if (mtvec_out !== 32'h0 || mepc_out !== 32'h0 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: mtvec=%h mepc=%h irq=%b required 0 0 0", mtvec_out, mepc_out, irq_pending);
        end
        csr_raddr = 12'h300; #1;
        checks++;
        if (csr_rdata !== 32'h1800) begin
            errors++;
            $display("FAIL reset_mstatus: got %h required 00001800", csr_rdata);
        end
        csr_raddr = 12'h301; #1;
        checks++;
        if (csr_rdata !== 32'h4000_0100 || csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL misa: got %h ill=%b required 40000100 ill=0", csr_rdata, csr_illegal);
        end
        csr_raddr = 12'hF14; #1;
        checks++;
        if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL mhartid: got %h ill=%b required 0 ill=0", csr_rdata, csr_illegal);
        end
        csr_raddr = 12'h7C0; #1;
        checks++;
        if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_7c0: got %h ill=%b required 0 ill=1", csr_rdata, csr_illegal);
        end
    endtask

    task automatic test_mtvec_align();
        csr_write(12'h305, 32'h8000_0103);
        csr_raddr = 12'h305; #1;
        checks++;
        if (csr_rdata !== 32'h8000_0100 || mtvec_out !== 32'h8000_0100) begin
            errors++;
            $display("FAIL mtvec_align: rdata=%h out=%h required 80000100", csr_rdata, mtvec_out);
        end
        csr_write(12'h301, 32'h0);
        csr_write(12'hF14, 32'hFFFF_FFFF);
        csr_raddr = 12'h301; #1;
        checks++;
        if (csr_rdata !== 32'h4000_0100 || csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL misa_write_ignored: got %h ill=%b required 40000100 ill=0", csr_rdata, csr_illegal);
        end
    endtask

    task automatic test_trap_mret();
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        irq_ext = 1; #1;
        checks++;
        if (irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL irq_pending_set: got %b required 1", irq_pending);
        end
        trap_en = 1; trap_pc = 32'h104; trap_cause = 32'h8000_000B; trap_val = 32'hABCD;
        tick();
        trap_en = 0;
        csr_raddr = 12'h342; #1;
        checks++;
        if (mepc_out !== 32'h104 || csr_rdata !== 32'h8000_000B) begin
            errors++;
            $display("FAIL trap_entry: mepc=%h mcause=%h required 00000104 8000000b", mepc_out, csr_rdata);
        end
        csr_raddr = 12'h300; #1;
        checks++;
        if (csr_rdata !== 32'h1880 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL trap_status: mstatus=%h irq=%b required 00001880 0", csr_rdata, irq_pending);
        end
        mret_en = 1;
        tick();
        mret_en = 0;
        #1;
        checks++;
        if (csr_rdata !== 32'h1888 || irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL mret_status: mstatus=%h irq=%b required 00001888 1", csr_rdata, irq_pending);
        end
        irq_ext = 0;
    endtask

    task automatic test_priority();
        trap_en = 1; trap_pc = 32'h300; csr_wen = 1; csr_waddr = 12'h341; csr_wdata = 32'h200;
        tick();
        checks++;
        if (mepc_out !== 32'h300) begin
            errors++;
            $display("FAIL trap_over_write_mepc: got %h required 00000300", mepc_out);
        end
        csr_waddr = 12'h340; csr_wdata = 32'h55; trap_pc = 32'h400;
        tick();
        trap_en = 0; csr_wen = 0;
        csr_raddr = 12'h340; #1;
        checks++;
        if (csr_rdata !== 32'h55 || mepc_out !== 32'h400) begin
            errors++;
            $display("FAIL trap_with_mscratch: mscratch=%h mepc=%h required 00000055 00000400", csr_rdata, mepc_out);
        end
        mret_en = 1; csr_wen = 1; csr_waddr = 12'h300; csr_wdata = 32'h0;
        tick();
        mret_en = 0; csr_wen = 0;
        csr_raddr = 12'h300; #1;
        checks++;
        if (csr_rdata !== 32'h1880) begin
            errors++;
            $display("FAIL mret_over_write_status: got %h required 00001880", csr_rdata);
        end
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0);
        tick();
        csr_raddr = 12'hB00; #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mcycle_lo_carry: got %h required 0", csr_rdata);
        end
        csr_raddr = 12'hB80; #1;
        checks++;
        if (csr_rdata !== 32'h1) begin
            errors++;
            $display("FAIL mcycle_hi_carry: got %h required 1", csr_rdata);
        end
        instret_pulse = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                csr_wen = 1; csr_waddr = 12'hB02; csr_wdata = 32'h10;
            end
            tick();
            csr_wen = 0;
        end
        instret_pulse = 0;
        csr_raddr = 12'hB02; #1;
        checks++;
        if (csr_rdata !== 32'h12) begin
            errors++;
            $display("FAIL minstret_load: got %h required 00000012", csr_rdata);
        end
`else
        csr_write(12'hB00, 32'h1234);
        instret_pulse = 1;
        tick();
        tick();
        instret_pulse = 0;
        for (int i = 9; i < 13; i++) begin
            csr_raddr = addr_tab[i]; #1;
            checks++;
            if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
                errors++;
                $display("FAIL counter_absent_%h: got %h ill=%b required 0 ill=0", csr_raddr, csr_rdata, csr_illegal);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        bit exp_ill;
        for (int n = 0; n < 400; n++) begin
            csr_wen = ($urandom_range(0, 1) == 1);
            csr_waddr = addr_tab[$urandom_range(0, 15)];
            csr_wdata = $urandom;
            instret_pulse = $urandom_range(0, 1);
            trap_en = ($urandom_range(0, 7) == 0);
            mret_en = ($urandom_range(0, 7) == 0);
            trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
            irq_ext = $urandom_range(0, 1);
            irq_timer = $urandom_range(0, 1);
            irq_soft = $urandom_range(0, 1);
            csr_raddr = addr_tab[$urandom_range(0, 15)];
            rst = ($urandom_range(0, 99) == 0);
            tick();
            rst = 0;
            exp_read(csr_raddr, exp_d, exp_ill);
            checks++;
            if (csr_rdata !== exp_d || csr_illegal !== exp_ill || mtvec_out !== m_tvec || mepc_out !== m_epc
                || irq_pending !== (m_mie && ((m_mip() & m_ie) != 0))) begin
                errors++;
                $display("FAIL random_%0d addr=%h: rdata=%h ill=%b tvec=%h epc=%h irq=%b required %h %b %h %h %b",
                         n, csr_raddr, csr_rdata, csr_illegal, mtvec_out, mepc_out, irq_pending,
                         exp_d, exp_ill, m_tvec, m_epc, (m_mie && ((m_mip() & m_ie) != 0)));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_mtvec_align();
        test_trap_mret();
        test_priority();
        test_counters();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
